// File: rtl/compl_div_seq.sv
// compl_div_seq: iterative complex divider q = a / b.
// Operands are signed Q2.16, results signed Q3.16 with saturation.
// Quotients come from a restoring shift-subtract divider; real and
// imaginary parts run in parallel against a shared denominator.
// Build option COMPL_DIV_ROUND_EN: one extra quotient bit, result
// rounded half away from zero instead of truncated toward zero.
module compl_div_seq #(
  parameter int unsigned IN_W   = 18,
  parameter int unsigned OUT_W  = 19,
  parameter int unsigned FRAC_W = 16
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [IN_W-1:0]  data_a_i_i,
  input  logic signed [IN_W-1:0]  data_a_q_i,
  input  logic signed [IN_W-1:0]  data_b_i_i,
  input  logic signed [IN_W-1:0]  data_b_q_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [OUT_W-1:0] data_i_o,
  output logic signed [OUT_W-1:0] data_q_o,
  output logic                    div_zero_o
);

`ifdef COMPL_DIV_ROUND_EN
  localparam int unsigned ITER = OUT_W + 1;
  localparam int unsigned QR_W = ITER + 1;
`else
  localparam int unsigned ITER = OUT_W;
`endif
  localparam int unsigned PROD_W = 2 * IN_W + 1;
  localparam int unsigned SHIFT  = FRAC_W + ITER - OUT_W;
  localparam int unsigned DVD_W  = PROD_W + SHIFT;
  localparam int unsigned CMP_W  = PROD_W + OUT_W;
  localparam int unsigned CNT_W  = $clog2(ITER);
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [ITER-1:0]  MAG_LIM = ITER'(1) << (OUT_W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nx;
  logic   load_op, load_mul, step, fin;
  logic   in_ready_nx, out_valid_nx;

  logic signed [IN_W-1:0] op_a_i, op_a_q, op_b_i, op_b_q;
  logic [PROD_W-1:0]      den;
  logic [PROD_W-1:0]      rem_i, rem_q;
  logic [ITER-1:0]        low_i, low_q, quo_i, quo_q;
  logic                   neg_i, neg_q, ovf_i, ovf_q, dz;
  logic [CNT_W-1:0]       cnt;

  logic signed [PROD_W-1:0] num_i_c, num_q_c, den_c;
  logic [PROD_W-1:0]        mag_i_c, mag_q_c;
  logic [DVD_W-1:0]         dvd_i_c, dvd_q_c;
  logic                     ovf_i_c, ovf_q_c;
  logic [PROD_W:0]          step_i_c, step_q_c;

  // One restoring step: returns {quotient bit, new partial remainder}.
  function automatic logic [PROD_W:0] div_step(input logic [PROD_W-1:0] rem,
                                               input logic              din,
                                               input logic [PROD_W-1:0] d);
    logic [PROD_W:0] t;
    t = {rem, din};
    if (t >= {1'b0, d}) div_step = {1'b1, PROD_W'(t - {1'b0, d})};
    else                div_step = {1'b0, PROD_W'(t)};
  endfunction

  // Turn an unsigned quotient into the signed, saturated result.
  function automatic logic [OUT_W-1:0] finalize(input logic [ITER-1:0] quo,
                                                input logic            neg,
                                                input logic            ovf);
    logic [ITER-1:0] mag;
`ifdef COMPL_DIV_ROUND_EN
    mag = ITER'((QR_W'(quo) + QR_W'(1)) >> 1);
`else
    mag = quo;
`endif
    if (ovf || (mag >= MAG_LIM)) finalize = neg ? SAT_NEG : SAT_POS;
    else if (neg)                finalize = OUT_W'(-mag);
    else                         finalize = OUT_W'(mag);
  endfunction

  // Full-precision numerators, denominator and overflow pre-check.
  always_comb begin
    num_i_c = PROD_W'(op_a_i) * PROD_W'(op_b_i) + PROD_W'(op_a_q) * PROD_W'(op_b_q);
    num_q_c = PROD_W'(op_a_q) * PROD_W'(op_b_i) - PROD_W'(op_a_i) * PROD_W'(op_b_q);
    den_c   = PROD_W'(op_b_i) * PROD_W'(op_b_i) + PROD_W'(op_b_q) * PROD_W'(op_b_q);
    mag_i_c = num_i_c[PROD_W-1] ? $unsigned(-num_i_c) : $unsigned(num_i_c);
    mag_q_c = num_q_c[PROD_W-1] ? $unsigned(-num_q_c) : $unsigned(num_q_c);
    dvd_i_c = DVD_W'(mag_i_c) << SHIFT;
    dvd_q_c = DVD_W'(mag_q_c) << SHIFT;
    ovf_i_c = (CMP_W'(mag_i_c) << FRAC_W) >= (CMP_W'($unsigned(den_c)) << (OUT_W - 1));
    ovf_q_c = (CMP_W'(mag_q_c) << FRAC_W) >= (CMP_W'($unsigned(den_c)) << (OUT_W - 1));
    step_i_c = div_step(rem_i, low_i[ITER-1], den);
    step_q_c = div_step(rem_q, low_q[ITER-1], den);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (srst_i) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and control decode.
  always_comb begin
    state_nx     = state;
    load_op      = 1'b0;
    load_mul     = 1'b0;
    step         = 1'b0;
    fin          = 1'b0;
    out_valid_nx = out_valid_o;
    unique case (state)
      IDLE: if (in_valid_i && in_ready_o) begin
        load_op  = 1'b1;
        state_nx = MUL;
      end
      MUL: begin
        load_mul = 1'b1;
        state_nx = (den_c == '0) ? DONE : DIV;
      end
      DIV: begin
        step = 1'b1;
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        if (!out_valid_o) begin
          fin          = 1'b1;
          out_valid_nx = 1'b1;
        end else if (out_ready_i) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    in_ready_nx = (state_nx == IDLE);
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      data_i_o    <= '0;
      data_q_o    <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      in_ready_o  <= in_ready_nx;
      out_valid_o <= out_valid_nx;
      if (fin) begin
        data_i_o   <= dz ? '0 : finalize(quo_i, neg_i, ovf_i);
        data_q_o   <= dz ? '0 : finalize(quo_q, neg_q, ovf_q);
        div_zero_o <= dz;
      end
    end
  end

  // Operand capture, divider setup and iteration.
  always_ff @(posedge clk_i) begin
    if (load_op) begin
      op_a_i <= data_a_i_i;
      op_a_q <= data_a_q_i;
      op_b_i <= data_b_i_i;
      op_b_q <= data_b_q_i;
    end
    if (load_mul) begin
      den   <= $unsigned(den_c);
      dz    <= (den_c == '0);
      neg_i <= num_i_c[PROD_W-1];
      neg_q <= num_q_c[PROD_W-1];
      ovf_i <= ovf_i_c;
      ovf_q <= ovf_q_c;
      rem_i <= PROD_W'(dvd_i_c >> ITER);
      rem_q <= PROD_W'(dvd_q_c >> ITER);
      low_i <= dvd_i_c[ITER-1:0];
      low_q <= dvd_q_c[ITER-1:0];
      quo_i <= '0;
      quo_q <= '0;
      cnt   <= CNT_W'(ITER - 1);
    end
    if (step) begin
      rem_i <= step_i_c[PROD_W-1:0];
      rem_q <= step_q_c[PROD_W-1:0];
      quo_i <= {quo_i[ITER-2:0], step_i_c[PROD_W]};
      quo_q <= {quo_q[ITER-2:0], step_q_c[PROD_W]};
      low_i <= low_i << 1;
      low_q <= low_q << 1;
      cnt   <= cnt - CNT_W'(1);
    end
  end

endmodule
